// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp : two-write / two-read register file for the MIPS32 datapath.
//
// Read data is registered, one cycle of latency, with write-first bypass from
// the writes landing on the same edge. Port 2 wins a same-address write
// collision, and the collision is flagged for one cycle. With ZERO_REG set,
// register 0 reads as zero and ignores writes. Addresses at or above NUM_REGS
// read as zero and drop writes.
//
// Ports
//   clk, rst_n          clock (rising edge) / async active-low reset
//   rd_en               1: load rd_data1/2 this edge, 0: hold them
//   rd_addr1, rd_addr2  read addresses
//   we1, wa1, wd1       write port 1
//   we2, wa2, wd2       write port 2 (higher priority)
//   rd_data1, rd_data2  registered read data
//   wr_conflict         pulse: both ports wrote the same register last edge
// ---------------------------------------------------------------------------
module reg_file_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              we2,
    input  logic [ADDR_W-1:0] wa2,
    input  logic [DATA_W-1:0] wd2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              wr_conflict
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_rd_data1;
    logic [DATA_W-1:0] r_rd_data2;
    logic              r_wr_conflict;

    logic              w_wr1;
    logic              w_wr2;
    logic              w_conflict;
    logic [DATA_W-1:0] w_rd_val1;
    logic [DATA_W-1:0] w_rd_val2;

    // Address maps to a real, non-hardwired register.
    function automatic logic f_writable(input logic [ADDR_W-1:0] a);
        return (32'(a) < NUM_REGS) && !(ZERO_REG && (a == '0));
    endfunction

    // Effective write strobes and collision detect.
    always_comb begin
        w_wr1      = we1 && f_writable(wa1);
        w_wr2      = we2 && f_writable(wa2);
        w_conflict = w_wr1 && w_wr2 && (wa1 == wa2);
    end

    // Read value: array, then port-1 bypass, then port-2 bypass, then zero mask.
    always_comb begin
        w_rd_val1 = '0;
        w_rd_val2 = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (rd_addr1 == ADDR_W'(i)) w_rd_val1 = r_regs[i];
            if (rd_addr2 == ADDR_W'(i)) w_rd_val2 = r_regs[i];
        end
        if (w_wr1 && (wa1 == rd_addr1)) w_rd_val1 = wd1;
        if (w_wr2 && (wa2 == rd_addr1)) w_rd_val1 = wd2;
        if (!f_writable(rd_addr1))      w_rd_val1 = '0;
        if (w_wr1 && (wa1 == rd_addr2)) w_rd_val2 = wd1;
        if (w_wr2 && (wa2 == rd_addr2)) w_rd_val2 = wd2;
        if (!f_writable(rd_addr2))      w_rd_val2 = '0;
    end

    // Register array; port 2 overrides port 1 on the same address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (w_wr2 && (wa2 == ADDR_W'(i))) begin
                    r_regs[i] <= wd2;
                end else if (w_wr1 && (wa1 == ADDR_W'(i))) begin
                    r_regs[i] <= wd1;
                end
            end
        end
    end

    // Registered read data and collision pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data1    <= '0;
            r_rd_data2    <= '0;
            r_wr_conflict <= 1'b0;
        end else begin
            r_wr_conflict <= w_conflict;
            if (rd_en) begin
                r_rd_data1 <= w_rd_val1;
                r_rd_data2 <= w_rd_val2;
            end
        end
    end

    assign rd_data1    = r_rd_data1;
    assign rd_data2    = r_rd_data2;
    assign wr_conflict = r_wr_conflict;

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp : directed scenarios plus randomized traffic for reg_file_mp.
// Three instances share stimulus: default (0), ZERO_REG=0 (1), NUM_REGS=24 (2).
// ---------------------------------------------------------------------------
module tb_reg_file_mp;

    localparam int NI = 3;
    localparam bit ZR [NI] = '{1'b1, 1'b0, 1'b1};
    localparam int NR [NI] = '{32, 32, 24};

    logic        clk;
    logic        rst_n;
    logic        rd_en;
    logic [4:0]  rd_addr1, rd_addr2, wa1, wa2;
    logic        we1, we2;
    logic [31:0] wd1, wd2;

    logic [31:0] rd1_a, rd1_b, rd1_c, rd2_a, rd2_b, rd2_c;
    logic        cf_a, cf_b, cf_c;
    logic [31:0] rd1 [NI];
    logic [31:0] rd2 [NI];
    logic        cf  [NI];

    // Reference model state
    logic [31:0] m_regs [NI][32];
    logic [31:0] m_rd1  [NI];
    logic [31:0] m_rd2  [NI];
    logic        m_cf   [NI];

    int n_vec;
    int n_err;

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .ZERO_REG(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .we1(we1), .wa1(wa1), .wd1(wd1), .we2(we2), .wa2(wa2), .wd2(wd2),
        .rd_data1(rd1_a), .rd_data2(rd2_a), .wr_conflict(cf_a));

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .ZERO_REG(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .we1(we1), .wa1(wa1), .wd1(wd1), .we2(we2), .wa2(wa2), .wd2(wd2),
        .rd_data1(rd1_b), .rd_data2(rd2_b), .wr_conflict(cf_b));

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(24), .ZERO_REG(1'b1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .we1(we1), .wa1(wa1), .wd1(wd1), .we2(we2), .wa2(wa2), .wd2(wd2),
        .rd_data1(rd1_c), .rd_data2(rd2_c), .wr_conflict(cf_c));

    always_comb begin
        rd1[0] = rd1_a; rd1[1] = rd1_b; rd1[2] = rd1_c;
        rd2[0] = rd2_a; rd2[1] = rd2_b; rd2[2] = rd2_c;
        cf[0]  = cf_a;  cf[1]  = cf_b;  cf[2]  = cf_c;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_writable(input int k, input logic [4:0] a);
        return (int'(a) < NR[k]) && !(ZR[k] && (a == 5'd0));
    endfunction

    // Value a read of address a would capture on the coming edge.
    function automatic logic [31:0] m_value(input int k, input logic [4:0] a);
        if (!m_writable(k, a))     return 32'd0;
        if (we2 && (wa2 == a))     return wd2;
        if (we1 && (wa1 == a))     return wd1;
        return m_regs[k][int'(a)];
    endfunction

    task automatic m_clear();
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 32; i++) m_regs[k][i] = 32'd0;
            m_rd1[k] = 32'd0;
            m_rd2[k] = 32'd0;
            m_cf[k]  = 1'b0;
        end
    endtask

    task automatic idle();
        rd_en = 1'b0; we1 = 1'b0; we2 = 1'b0;
    endtask

    // One clock edge: predict, clock, commit prediction, settle.
    task automatic tick();
        logic [31:0] n1 [NI];
        logic [31:0] n2 [NI];
        logic        nc [NI];
        for (int k = 0; k < NI; k++) begin
            n1[k] = rd_en ? m_value(k, rd_addr1) : m_rd1[k];
            n2[k] = rd_en ? m_value(k, rd_addr2) : m_rd2[k];
            nc[k] = we1 && we2 && (wa1 == wa2) && m_writable(k, wa1);
        end
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            m_rd1[k] = n1[k];
            m_rd2[k] = n2[k];
            m_cf[k]  = nc[k];
            if (we1 && m_writable(k, wa1)) m_regs[k][int'(wa1)] = wd1;
            if (we2 && m_writable(k, wa2)) m_regs[k][int'(wa2)] = wd2;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle();
        rd_addr1 = 5'd0; rd_addr2 = 5'd0; wa1 = 5'd0; wa2 = 5'd0; wd1 = 32'd0; wd2 = 32'd0;
        m_clear();
        #2;
        for (int k = 0; k < NI; k++) begin
            n_vec++;
            if (rd1[k] !== 32'd0 || rd2[k] !== 32'd0 || cf[k] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_init dut%0d: got rd1=%h rd2=%h cf=%b, want 0/0/0", k, rd1[k], rd2[k], cf[k]);
            end
        end
        rst_n = 1'b1;
        we1 = 1'b1; wa1 = 5'd5; wd1 = 32'hDEADBEEF;
        tick();
        idle(); rd_en = 1'b1; rd_addr1 = 5'd5; rd_addr2 = 5'd5;
        tick();
        n_vec++;
        if (rd1_a !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL reset_preload: got %h, want deadbeef", rd1_a);
        end
        // Mid-cycle reset, including a pending write that must be lost
        we1 = 1'b1; wa1 = 5'd6; wd1 = 32'h0BADF00D;
        #2 rst_n = 1'b0;
        m_clear();
        #1;
        for (int k = 0; k < NI; k++) begin
            n_vec++;
            if (rd1[k] !== 32'd0 || rd2[k] !== 32'd0) begin
                n_err++;
                $display("FAIL reset_async dut%0d: got rd1=%h rd2=%h, want 0", k, rd1[k], rd2[k]);
            end
        end
        idle();
        #1 rst_n = 1'b1;
        rd_en = 1'b1; rd_addr1 = 5'd5; rd_addr2 = 5'd6;
        tick();
        n_vec++;
        if (rd1_a !== 32'd0 || rd2_a !== 32'd0) begin
            n_err++;
            $display("FAIL reset_cleared: got r5=%h r6=%h, want 0", rd1_a, rd2_a);
        end
    endtask

    task automatic test_write_read();
        idle(); we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h12345678;
        tick();
        idle(); rd_en = 1'b1; rd_addr1 = 5'd3;
        tick();
        n_vec++;
        if (rd1_a !== 32'h12345678) begin
            n_err++;
            $display("FAIL write_read: got %h, want 12345678", rd1_a);
        end
    endtask

    task automatic test_bypass();
        idle(); rd_en = 1'b1;
        we2 = 1'b1; wa2 = 5'd7; wd2 = 32'hA5A5A5A5; rd_addr2 = 5'd7;
        we1 = 1'b1; wa1 = 5'd8; wd1 = 32'h5A5A0001; rd_addr1 = 5'd8;
        tick();
        n_vec++;
        if (rd2_a !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL bypass_p2: got %h, want a5a5a5a5", rd2_a);
        end
        n_vec++;
        if (rd1_a !== 32'h5A5A0001) begin
            n_err++;
            $display("FAIL bypass_p1: got %h, want 5a5a0001", rd1_a);
        end
        // Both ports to the same read address: port 2 data wins
        we1 = 1'b1; wa1 = 5'd10; wd1 = 32'h0000AAAA;
        we2 = 1'b1; wa2 = 5'd10; wd2 = 32'h0000BBBB;
        rd_addr1 = 5'd10; rd_addr2 = 5'd10;
        tick();
        n_vec++;
        if (rd1_a !== 32'h0000BBBB || rd2_a !== 32'h0000BBBB) begin
            n_err++;
            $display("FAIL bypass_prio: got %h/%h, want 0000bbbb", rd1_a, rd2_a);
        end
    endtask

    task automatic test_collision();
        idle();
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h1111;
        we2 = 1'b1; wa2 = 5'd9; wd2 = 32'h2222;
        tick();
        n_vec++;
        if (cf_a !== 1'b1) begin
            n_err++;
            $display("FAIL collision_flag: got %b, want 1", cf_a);
        end
        idle(); rd_en = 1'b1; rd_addr1 = 5'd9;
        tick();
        n_vec++;
        if (cf_a !== 1'b0 || rd1_a !== 32'h2222) begin
            n_err++;
            $display("FAIL collision_after: got cf=%b r9=%h, want 0 and 00002222", cf_a, rd1_a);
        end
        idle();
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'h1111;
        we2 = 1'b1; wa2 = 5'd0; wd2 = 32'h2222;
        tick();
        n_vec++;
        if (cf_a !== 1'b0 || cf_b !== 1'b1) begin
            n_err++;
            $display("FAIL collision_r0: got cf zr1=%b zr0=%b, want 0 and 1", cf_a, cf_b);
        end
        idle(); rd_en = 1'b1; rd_addr1 = 5'd0;
        tick();
        n_vec++;
        if (rd1_a !== 32'd0 || rd1_b !== 32'h2222) begin
            n_err++;
            $display("FAIL collision_r0_read: got zr1=%h zr0=%h, want 0 and 00002222", rd1_a, rd1_b);
        end
    endtask

    task automatic test_zero_range();
        idle(); we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF;
        tick();
        idle(); rd_en = 1'b1; rd_addr1 = 5'd0;
        tick();
        n_vec++;
        if (rd1_a !== 32'd0 || rd1_b !== 32'hFFFF) begin
            n_err++;
            $display("FAIL zero_reg: got zr1=%h zr0=%h, want 0 and 0000ffff", rd1_a, rd1_b);
        end
        idle(); we2 = 1'b1; wa2 = 5'd30; wd2 = 32'hC0FFEE30;
        tick();
        idle(); rd_en = 1'b1; rd_addr1 = 5'd30;
        tick();
        n_vec++;
        if (rd1_c !== 32'd0 || rd1_a !== 32'hC0FFEE30) begin
            n_err++;
            $display("FAIL range_r30: got n24=%h n32=%h, want 0 and c0ffee30", rd1_c, rd1_a);
        end
        for (int i = 0; i < 24; i++) begin
            idle(); rd_en = 1'b1; rd_addr1 = 5'(i);
            tick();
            n_vec++;
            if (rd1_c !== m_regs[2][i]) begin
                n_err++;
                $display("FAIL range_keep r%0d: got %h, want %h", i, rd1_c, m_regs[2][i]);
            end
        end
    endtask

    task automatic test_hold();
        idle(); rd_en = 1'b1; rd_addr1 = 5'd3;
        tick();
        for (int c = 0; c < 3; c++) begin
            idle(); we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h77;
            rd_addr1 = 5'(c + 4);
            #2 rd_addr1 = 5'(c + 11);
            tick();
            n_vec++;
            if (rd1_a !== 32'h12345678) begin
                n_err++;
                $display("FAIL hold cycle%0d: got %h, want 12345678", c, rd1_a);
            end
        end
        idle(); rd_en = 1'b1; rd_addr1 = 5'd4;
        tick();
        n_vec++;
        if (rd1_a !== 32'h77) begin
            n_err++;
            $display("FAIL hold_release: got %h, want 00000077", rd1_a);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rd_en    = ($urandom_range(0, 3) != 0);
            rd_addr1 = 5'($urandom);
            rd_addr2 = ($urandom_range(0, 3) == 0) ? rd_addr1 : 5'($urandom);
            we1      = $urandom_range(0, 1) == 1;
            we2      = $urandom_range(0, 1) == 1;
            wa1      = ($urandom_range(0, 2) == 0) ? rd_addr1 : 5'($urandom);
            wa2      = ($urandom_range(0, 3) == 0) ? wa1 : 5'($urandom);
            wd1      = $urandom;
            wd2      = $urandom;
            if ($urandom_range(0, 149) == 0) begin
                #1 rst_n = 1'b0;
                m_clear();
                #1 rst_n = 1'b1;
            end
            tick();
            for (int k = 0; k < NI; k++) begin
                n_vec++;
                if (rd1[k] !== m_rd1[k]) begin
                    n_err++;
                    $display("FAIL rand_rd1 dut%0d iter%0d: got %h, want %h", k, n, rd1[k], m_rd1[k]);
                end
                n_vec++;
                if (rd2[k] !== m_rd2[k]) begin
                    n_err++;
                    $display("FAIL rand_rd2 dut%0d iter%0d: got %h, want %h", k, n, rd2[k], m_rd2[k]);
                end
                n_vec++;
                if (cf[k] !== m_cf[k]) begin
                    n_err++;
                    $display("FAIL rand_conflict dut%0d iter%0d: got %b, want %b", k, n, cf[k], m_cf[k]);
                end
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_collision();
        test_zero_range();
        test_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
